cla_32: RTL and testbench

CLA_32 -- requirements
Module: cla_32

---
 rtl/cla_pkg.sv | 6 +
 rtl/cla4_block.sv | 29 ++
 rtl/cla_32.sv | 66 ++++++
 tb/tb_cla_32.sv | 122 ++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared width constants for the 32-bit two-level carry-lookahead adder.
package cla_pkg;
  localparam int unsigned CLA_WIDTH = 32;
  localparam int unsigned CLA_BLOCK = 4;
  localparam int unsigned CLA_NBLK  = CLA_WIDTH / CLA_BLOCK;
endpackage

// File: rtl/cla4_block.sv
// 4-bit carry-lookahead block: local sums plus group generate/propagate.
module cla4_block (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       G,
  output logic       P
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Carries are flattened sum-of-products, no ripple between bits.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign s = p ^ c;

  assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
  assign P = &p;
endmodule

// File: rtl/cla_32.sv
// 32-bit registered adder: eight cla4_block groups with a second-level lookahead unit.
module cla_32
  import cla_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [CLA_WIDTH-1:0] X,
  input  logic [CLA_WIDTH-1:0] Y,
  input  logic                 CARRY_IN,
  output logic [CLA_WIDTH-1:0] SUM,
  output logic                 CARRY_OUT
);
  logic [CLA_NBLK-1:0]  blk_g;
  logic [CLA_NBLK-1:0]  blk_p;
  logic [CLA_NBLK:0]    blk_c;
  logic [CLA_WIDTH-1:0] sum_d;
  logic [CLA_WIDTH-1:0] sum_q;
  logic                 cout_d;
  logic                 cout_q;

  for (genvar k = 0; k < CLA_NBLK; k++) begin : g_blk
    cla4_block u_blk (
      .a   (X[k*CLA_BLOCK +: CLA_BLOCK]),
      .b   (Y[k*CLA_BLOCK +: CLA_BLOCK]),
      .cin (blk_c[k]),
      .s   (sum_d[k*CLA_BLOCK +: CLA_BLOCK]),
      .G   (blk_g[k]),
      .P   (blk_p[k])
    );
  end

  // Each block carry-in is the OR of every generate term reaching it,
  // expanded into products so no carry depends on another carry.
  always_comb begin
    logic term;
    logic prod;
    blk_c    = '0;
    blk_c[0] = CARRY_IN;
    for (int unsigned k = 0; k < CLA_NBLK; k++) begin
      term = 1'b0;
      for (int unsigned j = 0; j <= k; j++) begin
        prod = blk_g[j];
        for (int unsigned m = j + 1; m <= k; m++) prod = prod & blk_p[m];
        term = term | prod;
      end
      prod = CARRY_IN;
      for (int unsigned m = 0; m <= k; m++) prod = prod & blk_p[m];
      blk_c[k+1] = term | prod;
    end
  end

  assign cout_d = blk_c[CLA_NBLK];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign SUM       = sum_q;
  assign CARRY_OUT = cout_q;
endmodule

// File: tb/tb_cla_32.sv
// Directed-table and random checks for the registered 32-bit lookahead adder.
module tb_cla_32;
  logic        CLK;
  logic        RST;
  logic [31:0] X;
  logic [31:0] Y;
  logic        CARRY_IN;
  logic [31:0] SUM;
  logic        CARRY_OUT;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [31:0] x;
    logic [31:0] y;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs [9];

  cla_32 dut (
    .CLK       (CLK),
    .RST       (RST),
    .X         (X),
    .Y         (Y),
    .CARRY_IN  (CARRY_IN),
    .SUM       (SUM),
    .CARRY_OUT (CARRY_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] exp_sum, input logic exp_cout);
    checks++;
    if (SUM !== exp_sum || CARRY_OUT !== exp_cout) begin
      errors++;
      $display("FAIL %s: got SUM=%08h CARRY_OUT=%b, expected SUM=%08h CARRY_OUT=%b",
               name, SUM, CARRY_OUT, exp_sum, exp_cout);
    end
  endtask

  task automatic apply(input logic [31:0] x, input logic [31:0] y, input logic cin);
    X = x;
    Y = y;
    CARRY_IN = cin;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [32:0] ref_val;

    vecs[0] = '{"zero",        32'd0,        32'd0,        1'b0, 32'd0,        1'b0};
    vecs[1] = '{"1+5",         32'd1,        32'd5,        1'b0, 32'd6,        1'b0};
    vecs[2] = '{"5+5",         32'd5,        32'd5,        1'b0, 32'd10,       1'b0};
    vecs[3] = '{"122+688",     32'd122,      32'd688,      1'b0, 32'd810,      1'b0};
    vecs[4] = '{"-100+-455",   32'hFFFFFF9C, 32'hFFFFFE39, 1'b0, 32'hFFFFFDD5, 1'b1};
    vecs[5] = '{"-100+200",    32'hFFFFFF9C, 32'd200,      1'b0, 32'd100,      1'b1};
    vecs[6] = '{"-200+100",    32'hFFFFFF38, 32'd100,      1'b0, 32'hFFFFFF9C, 1'b0};
    vecs[7] = '{"ones+0+1",    32'hFFFFFFFF, 32'd0,        1'b1, 32'd0,        1'b1};
    vecs[8] = '{"155+354+1",   32'd155,      32'd354,      1'b1, 32'd510,      1'b0};

    RST = 1'b1;
    X = 32'hDEADBEEF;
    Y = 32'h12345678;
    CARRY_IN = 1'b1;
    #1;
    check("reset_state", 32'd0, 1'b0);
    @(posedge CLK);
    #1;
    check("reset_held_over_edge", 32'd0, 1'b0);
    RST = 1'b0;

    for (int i = 0; i < 9; i++) begin
      apply(vecs[i].x, vecs[i].y, vecs[i].cin);
      check(vecs[i].name, vecs[i].sum, vecs[i].cout);
    end

    // Asynchronous reset between edges, pending operands discarded.
    apply(32'd122, 32'd688, 1'b0);
    check("pre_reset_810", 32'd810, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    check("async_reset_immediate", 32'd0, 1'b0);
    X = 32'd1;
    Y = 32'd5;
    @(posedge CLK);
    #1;
    check("reset_discards_pending", 32'd0, 1'b0);
    #2;
    RST = 1'b0;
    #1;
    check("deassert_no_edge", 32'd0, 1'b0);
    @(posedge CLK);
    #1;
    check("first_edge_after_reset", 32'd6, 1'b0);

    // Full-throughput random operands, one result per cycle.
    for (int n = 0; n < 10000; n++) begin
      logic [31:0] rx;
      logic [31:0] ry;
      logic        rc;
      rx = $urandom;
      ry = $urandom;
      rc = 1'($urandom_range(0, 1));
      if (n % 97 == 0) rx = 32'hFFFFFFFF;
      if (n % 89 == 0) ry = ~rx;
      ref_val = {1'b0, rx} + {1'b0, ry} + {32'd0, rc};
      apply(rx, ry, rc);
      check("random", ref_val[31:0], ref_val[32]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
